// File: rtl/sum_display_driver.sv
// sum_display_driver: captures a 5-bit adder result, converts it to two BCD
// digits with a sequential shift-add-3 engine, and scans them onto a 4-digit
// common-anode seven-segment display.
module sum_display_driver #(
  parameter int REFRESH_BITS = 17,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] sum,
  output logic       busy,
  output logic       done,
  output logic [3:0] an,
  output logic [6:0] seg
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  state_t                  state, state_nx;
  logic [4:0]              sr;
  logic [7:0]              bcd;
  logic [2:0]              cnt;
  logic [3:0]              tens, ones;
  logic [7:0]              bcd_adj;
  logic [12:0]             shifted;
  logic [REFRESH_BITS-1:0] presc;
  logic [1:0]              idx;

  // active-low {g..a} pattern for one decimal digit; anything else is blank
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // add-3 correction on each BCD nibble, then the one-bit left shift
  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
    shifted = {bcd_adj, sr} << 1;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state and status outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE:  if (load) state_nx = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (cnt == 3'd4) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // conversion datapath; display digits only change after the last shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr   <= '0;
      bcd  <= '0;
      cnt  <= '0;
      tens <= '0;
      ones <= '0;
    end else begin
      case (state)
        IDLE: if (load) begin
          sr  <= sum;
          bcd <= '0;
          cnt <= '0;
        end
        SHIFT: begin
          bcd <= shifted[12:5];
          sr  <= shifted[4:0];
          cnt <= cnt + 3'd1;
          if (cnt == 3'd4) begin
            tens <= shifted[12:9];
            ones <= shifted[8:5];
          end
        end
        default: ;
      endcase
    end
  end

  // free-running prescaler; digit index steps on each wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else begin
      presc <= presc + 1'b1;
      if (presc == '1) idx <= idx + 2'd1;
    end
  end

  // registered anode/segment decode from digit index and display digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 4'b1111;
      seg <= SEG_BLANK;
    end else begin
      case (idx)
        2'd0: begin
          an  <= 4'b1110;
          seg <= seg7(ones);
        end
        2'd1: begin
          an  <= 4'b1101;
          seg <= (BLANK_LZ && tens == 4'd0) ? SEG_BLANK : seg7(tens);
        end
        2'd2: begin
          an  <= 4'b1011;
          seg <= SEG_BLANK;
        end
        default: begin
          an  <= 4'b0111;
          seg <= SEG_BLANK;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_display_driver.sv
// Directed bench for sum_display_driver: two instances with a short refresh
// period, one blanking the leading zero and one not.
module tb_sum_display_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [4:0] sum = 5'd0;
  logic       busy_a, done_a, busy_b, done_b;
  logic [3:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;

  int total = 0;
  int bad   = 0;
  int dcnt  = 0;
  logic [6:0] segtab [10];
  logic [6:0] s;
  logic [3:0] ea;

  localparam logic [6:0] BLK = 7'b1111111;

  sum_display_driver #(.REFRESH_BITS(3), .BLANK_LZ(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .load(load), .sum(sum),
    .busy(busy_a), .done(done_a), .an(an_a), .seg(seg_a)
  );

  sum_display_driver #(.REFRESH_BITS(3), .BLANK_LZ(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .load(load), .sum(sum),
    .busy(busy_b), .done(done_b), .an(an_b), .seg(seg_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done_a === 1'b1) dcnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_load(input logic [4:0] v);
    @(negedge clk);
    load = 1'b1;
    sum  = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done_a !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done_a), 32'd1);
  endtask

  // wait (bounded) until the chosen instance drives target anode; grab seg
  task automatic read_digit(input bit b, input logic [3:0] tgt, output logic [6:0] so);
    so = 'x;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if ((b ? an_b : an_a) === tgt) begin
        so = b ? seg_b : seg_a;
        break;
      end
    end
  endtask

  initial begin
    segtab[0] = 7'b1000000; segtab[1] = 7'b1111001; segtab[2] = 7'b0100100;
    segtab[3] = 7'b0110000; segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010; segtab[7] = 7'b1111000; segtab[8] = 7'b0000000;
    segtab[9] = 7'b0010000;

    // reset state
    repeat (3) @(negedge clk);
    check("rst an", 32'(an_a), 32'hF);
    check("rst seg", 32'(seg_a), 32'(BLK));
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);

    // release and watch the refresh scan: 8 clocks per digit
    rst_n = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clk);
      if (k == 1 || k % 8 == 0 || k % 8 == 1) begin
        ea = 4'b1111 ^ (4'b0001 << (((k - 1) / 8) % 4));
        check($sformatf("scan an k=%0d", k), 32'(an_a), 32'(ea));
      end
      if (k == 1) check("first seg", 32'(seg_a), 32'(segtab[0]));
    end

    // conversion of 31 with exact busy/done timing; sum wiggles while busy
    pulse_load(5'd31);
    check("c31 busy N", 32'(busy_a), 32'd1);
    check("c31 done N", 32'(done_a), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 2) sum = 5'd0;
      check($sformatf("c31 busy N+%0d", i), 32'(busy_a), 32'd1);
      check($sformatf("c31 done N+%0d", i), 32'(done_a), (i == 5) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    check("c31 busy N+6", 32'(busy_a), 32'd0);
    check("c31 done N+6", 32'(done_a), 32'd0);
    read_digit(1'b0, 4'b1110, s);
    check("c31 ones", 32'(s), 32'(segtab[1]));
    read_digit(1'b0, 4'b1101, s);
    check("c31 tens", 32'(s), 32'(segtab[3]));

    // leading-zero blanking
    pulse_load(5'd7);
    wait_done("c7 done");
    read_digit(1'b0, 4'b1110, s);
    check("c7 ones", 32'(s), 32'(segtab[7]));
    read_digit(1'b0, 4'b1101, s);
    check("c7 tens blanked", 32'(s), 32'(BLK));
    read_digit(1'b1, 4'b1101, s);
    check("c7 tens shown", 32'(s), 32'(segtab[0]));
    read_digit(1'b0, 4'b1011, s);
    check("c7 digit2", 32'(s), 32'(BLK));
    read_digit(1'b0, 4'b0111, s);
    check("c7 digit3", 32'(s), 32'(BLK));

    // every input value, read back through the non-blanking instance
    for (int v = 0; v < 32; v++) begin
      pulse_load(5'(v));
      wait_done($sformatf("ex%0d done", v));
      read_digit(1'b1, 4'b1110, s);
      check($sformatf("ex%0d ones", v), 32'(s), 32'(segtab[v % 10]));
      read_digit(1'b1, 4'b1101, s);
      check($sformatf("ex%0d tens", v), 32'(s), 32'(segtab[v / 10]));
    end

    // busy rejection: load during SHIFT ignored, later one accepted
    @(negedge clk);
    dcnt = 0;
    load = 1'b1; sum = 5'd10;          // sampled at N
    @(negedge clk); load = 1'b0;       // after N
    @(negedge clk); load = 1'b1; sum = 5'd25;  // sampled at N+2
    @(negedge clk); load = 1'b0;       // after N+2
    repeat (3) @(negedge clk);         // after N+5
    check("rej first done", 32'(done_a), 32'd1);
    load = 1'b1;                       // held over N+6 and N+7
    @(negedge clk);
    @(negedge clk);
    load = 1'b0;
    repeat (12) @(negedge clk);
    check("rej done count", 32'(dcnt), 32'd2);
    read_digit(1'b0, 4'b1110, s);
    check("rej ones", 32'(s), 32'(segtab[5]));
    read_digit(1'b0, 4'b1101, s);
    check("rej tens", 32'(s), 32'(segtab[2]));

    // reset mid-conversion of 19
    pulse_load(5'd19);                 // after N
    @(negedge clk);
    @(negedge clk);                    // after N+2
    dcnt  = 0;
    rst_n = 1'b0;
    #1;
    check("abort busy", 32'(busy_a), 32'd0);
    check("abort done", 32'(done_a), 32'd0);
    check("abort an", 32'(an_a), 32'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("abort no done", 32'(dcnt), 32'd0);
    read_digit(1'b0, 4'b1110, s);
    check("abort ones", 32'(s), 32'(segtab[0]));
    read_digit(1'b0, 4'b1101, s);
    check("abort tens blanked", 32'(s), 32'(BLK));
    read_digit(1'b1, 4'b1101, s);
    check("abort tens shown", 32'(s), 32'(segtab[0]));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
